// File: rtl/spi_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bridge_pkg
//  Purpose  : Shared types and constants for the SPI word bridge: the
//             controller state encoding, default frame geometry and the
//             width of the optional abort counter (enabled by the
//             SPI_ABORT_CNT_EN macro in spi_word_bridge).
//  Revision : 1.0  initial release
// ============================================================================
package spi_bridge_pkg;

  // Default frame word width in bits.
  localparam int DEFAULT_WORD_W      = 16;
  // Default synchroniser depth for the SPI pins.
  localparam int DEFAULT_SYNC_STAGES = 2;
  // Width of the saturating frame-abort counter.
  localparam int ABORT_CNT_W         = 8;

  // WAIT_DESEL : wait for chip select to be released before joining a frame
  // IDLE       : deselected, waiting for a chip-select falling edge
  // SHIFT      : frame in progress
  typedef enum logic [1:0] {
    WAIT_DESEL = 2'd0,
    IDLE       = 2'd1,
    SHIFT      = 2'd2
  } spi_state_e;

endpackage : spi_bridge_pkg
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pin_sync
//  Purpose  : Multi-stage flip-flop synchroniser for one asynchronous pin,
//             with optional rise/fall edge detection on the synchronised
//             level (one extra register holds the previous level).
//  Ports    : clk      system clock
//             reset_n  asynchronous active-low reset
//             pin_i    asynchronous input pin
//             sync_o   synchronised level
//             rise_o   one-cycle pulse on a synchronised 0->1 transition
//             fall_o   one-cycle pulse on a synchronised 1->0 transition
//  Revision : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0,
  parameter bit   EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  // Fewer than two stages gives no metastability protection, so clamp.
  localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [DEPTH-1:0] chain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= {DEPTH{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[DEPTH-2:0], pin_i};
    end
  end

  assign sync_o = chain_q[DEPTH-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          prev_q <= RESET_VAL;
        end else begin
          prev_q <= chain_q[DEPTH-1];
        end
      end

      assign rise_o =  sync_o & ~prev_q;
      assign fall_o = ~sync_o &  prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule : spi_pin_sync
`default_nettype wire

// File: rtl/spi_word_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_word_bridge
//  Purpose  : Oversampled SPI mode-0 slave (MSB first) bridging an external
//             SPI master to a WORD_W-bit word port. All SPI pins are
//             synchronised into clk; nothing is clocked by SCLK.
//  Ports    : clk          system clock
//             reset_n      asynchronous active-low reset
//             spi_sclk     SPI clock from master (at most clk/8)
//             spi_cs_n     chip select, active low
//             spi_mosi     master-out data
//             spi_miso     slave-out data, registered
//             tx_word      word to transmit, sampled at CS fall and at the
//                          first SCLK fall after each completed word
//             rx_word      last completely received word
//             rx_valid     one-cycle pulse, rx_word updated in same cycle
//             frame_abort  one-cycle pulse when CS deasserts mid-word
//             busy         high while a frame is in progress
//             abort_cnt    saturating count of frame_abort pulses
//                          (present only with SPI_ABORT_CNT_EN defined)
//  Config   : `define SPI_ABORT_CNT_EN to add the abort counter output.
//  Revision : 1.0  initial release
// ============================================================================
module spi_word_bridge
  import spi_bridge_pkg::*;
#(
  parameter int WORD_W      = DEFAULT_WORD_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [WORD_W-1:0] tx_word,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_valid,
  output logic              frame_abort,
  output logic              busy
`ifdef SPI_ABORT_CNT_EN
  ,
  output logic [ABORT_CNT_W-1:0] abort_cnt
`endif
);

  localparam int               CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  // --------------------------------------------------------------------------
  // Pin conditioning
  // --------------------------------------------------------------------------
  logic       sclk_sync;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_sync;
  logic       cs_rise;
  logic       cs_fall;
  logic       mosi_sync;
  logic [1:0] mosi_edge_unused;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0),
    .EDGE_EN     (1'b1)
  ) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (spi_sclk),
    .sync_o  (sclk_sync),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // Chip select resets to "selected" so that, coming out of reset, the
  // controller cannot see a released CS until the pin really is high.
  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0),
    .EDGE_EN     (1'b1)
  ) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (spi_cs_n),
    .sync_o  (cs_sync),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0),
    .EDGE_EN     (1'b0)
  ) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (spi_mosi),
    .sync_o  (mosi_sync),
    .rise_o  (mosi_edge_unused[0]),
    .fall_o  (mosi_edge_unused[1])
  );

  // --------------------------------------------------------------------------
  // Controller state
  // --------------------------------------------------------------------------
  spi_state_e        state_q,  state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] rx_sh_q,  rx_sh_d;
  logic [WORD_W-1:0] tx_sh_q,  tx_sh_d;
  logic              reload_q, reload_d;
  logic              done_q,   done_d;
  logic              abort_d;
  logic [WORD_W-1:0] rx_word_q;
  logic              rx_valid_q;
  logic              frame_abort_q;
  logic              miso_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_DESEL;
      bitcnt_q      <= '0;
      rx_sh_q       <= '0;
      tx_sh_q       <= '0;
      reload_q      <= 1'b0;
      done_q        <= 1'b0;
      rx_word_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      rx_sh_q       <= rx_sh_d;
      tx_sh_q       <= tx_sh_d;
      reload_q      <= reload_d;
      done_q        <= done_d;
      // The word is published one cycle after its last bit is shifted in,
      // once rx_sh_q holds the complete word.
      if (done_q) begin
        rx_word_q <= rx_sh_q;
      end
      rx_valid_q    <= done_q;
      frame_abort_q <= abort_d;
      miso_q        <= (state_q == SHIFT) ? tx_sh_q[WORD_W-1] : 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_sh_d  = rx_sh_q;
    tx_sh_d  = tx_sh_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;

    case (state_q)
      WAIT_DESEL: begin
        // Never join a frame that was already running when reset released.
        if (cs_sync) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (cs_fall) begin
          tx_sh_d  = tx_word;
          bitcnt_d = '0;
          reload_d = 1'b0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        // CS release wins over any SCLK edge seen in the same cycle; that
        // edge is dropped. Only a release on a word boundary is clean.
        if (cs_rise) begin
          abort_d  = (bitcnt_q != '0);
          bitcnt_d = '0;
          reload_d = 1'b0;
          state_d  = IDLE;
        end else if (!cs_sync) begin
          if (sclk_rise) begin
            rx_sh_d = {rx_sh_q[WORD_W-2:0], mosi_sync};
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d = '0;
              done_d   = 1'b1;
              reload_d = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            // The first falling edge after a completed word fetches the
            // next outbound word instead of shifting.
            if (reload_q) begin
              tx_sh_d  = tx_word;
              reload_d = 1'b0;
            end else begin
              tx_sh_d = {tx_sh_q[WORD_W-2:0], 1'b0};
            end
          end
        end
      end

      default: begin
        state_d = WAIT_DESEL;
      end
    endcase
  end

  assign spi_miso    = miso_q;
  assign rx_word     = rx_word_q;
  assign rx_valid    = rx_valid_q;
  assign frame_abort = frame_abort_q;
  assign busy        = (state_q == SHIFT);

`ifdef SPI_ABORT_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating frame-abort counter, cleared only by reset
  // --------------------------------------------------------------------------
  logic [ABORT_CNT_W-1:0] abort_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abort_cnt_q <= '0;
    end else if (frame_abort_q && (abort_cnt_q != {ABORT_CNT_W{1'b1}})) begin
      abort_cnt_q <= abort_cnt_q + ABORT_CNT_W'(1);
    end
  end

  assign abort_cnt = abort_cnt_q;
`endif

endmodule : spi_word_bridge
`default_nettype wire

// File: tb/tb_spi_word_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_word_bridge
//  Purpose  : Directed self-checking bench for spi_word_bridge. Acts as the
//             SPI master (mode 0, SCLK = clk/8) and compares DUT outputs
//             with hand-computed expected values. Exercises the abort
//             counter when SPI_ABORT_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_word_bridge;

  localparam int WORD_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;   // clk cycles per SCLK half period

  logic              clk = 1'b0;
  logic              reset_n;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [WORD_W-1:0] tx_word;
  logic [WORD_W-1:0] rx_word;
  logic              rx_valid;
  logic              frame_abort;
  logic              busy;
`ifdef SPI_ABORT_CNT_EN
  logic [7:0]        abort_cnt;
`endif

  spi_word_bridge #(
    .WORD_W      (WORD_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .tx_word     (tx_word),
    .rx_word     (rx_word),
    .rx_valid    (rx_valid),
    .frame_abort (frame_abort),
    .busy        (busy)
`ifdef SPI_ABORT_CNT_EN
    ,
    .abort_cnt   (abort_cnt)
`endif
  );

  always #10 clk = ~clk;

  // Cycle counter and pulse monitors, sampled on the falling clock edge.
  int cyc        = 0;
  int valid_cnt  = 0;
  int valid_cyc  = 0;
  int abort_seen = 0;
  int rise_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (frame_abort) abort_seen = abort_seen + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(2);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  // Shift nbits MSB-first from mosi_w; MISO is sampled just before each
  // rising edge. With cs_on_last, CS is released together with the last
  // rising edge.
  task automatic spi_xfer(input int nbits, input logic [15:0] mosi_w,
                          input bit cs_on_last, output logic [15:0] miso_w);
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_w[15-i];
      tick(HALF);
      miso_w[15-i] = spi_miso;
      spi_sclk = 1'b1;
      if (cs_on_last && (i == nbits - 1)) spi_cs_n = 1'b1;
      rise_cyc = cyc;
      tick(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  logic [15:0] miso_a;
  logic [15:0] miso_b;
  int          v0;
  int          a0;

  initial begin
    reset_n  = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b0;
    spi_mosi = 1'b0;
    tx_word  = 16'h0000;
    tick(3);

    // Reset values
    check("rst_miso",  {31'd0, spi_miso},    32'd0);
    check("rst_rxw",   {16'd0, rx_word},     32'd0);
    check("rst_valid", {31'd0, rx_valid},    32'd0);
    check("rst_abort", {31'd0, frame_abort}, 32'd0);
    check("rst_busy",  {31'd0, busy},        32'd0);

    // 1: released from reset with CS already low -> burst ignored
    reset_n = 1'b1;
    tick(4);
    v0 = valid_cnt;
    spi_xfer(16, 16'h1357, 1'b0, miso_a);
    tick(8);
    check("join_busy",  {31'd0, busy},   32'd0);
    check("join_valid", valid_cnt - v0,  32'd0);
    cs_high();
    cs_low();
    spi_xfer(16, 16'hA5C3, 1'b0, miso_a);
    cs_high();
    check("t1_rxw",   {16'd0, rx_word}, 32'h0000A5C3);
    check("t1_valid", valid_cnt - v0,   32'd1);

    // 2: full-duplex word, latency of rx_valid
    tx_word = 16'h1234;
    v0 = valid_cnt;
    cs_low();
    check("t2_busy", {31'd0, busy}, 32'd1);
    spi_xfer(16, 16'hBEEF, 1'b0, miso_a);
    cs_high();
    check("t2_miso",    {16'd0, miso_a},      32'h00001234);
    check("t2_rxw",     {16'd0, rx_word},     32'h0000BEEF);
    check("t2_valid",   valid_cnt - v0,       32'd1);
    check("t2_latency", valid_cyc - rise_cyc, SYNC_STAGES + 2);

    // 3: two words under one CS
    tx_word = 16'h0F0F;
    v0 = valid_cnt;
    a0 = abort_seen;
    cs_low();
    spi_xfer(16, 16'h0001, 1'b0, miso_a);
    check("t3_rxw1", {16'd0, rx_word}, 32'h00000001);
    tx_word = 16'hFFFF;
    spi_xfer(16, 16'h8000, 1'b0, miso_b);
    cs_high();
    check("t3_miso1", {16'd0, miso_a},  32'h00000F0F);
    check("t3_miso2", {16'd0, miso_b},  32'h0000FFFF);
    check("t3_rxw2",  {16'd0, rx_word}, 32'h00008000);
    check("t3_valid", valid_cnt - v0,   32'd2);
    check("t3_abort", abort_seen - a0,  32'd0);

    // 4: CS released after 9 bits, then a clean frame
    v0 = valid_cnt;
    a0 = abort_seen;
    cs_low();
    spi_xfer(9, 16'hFFFF, 1'b0, miso_a);
    cs_high();
    check("t4_abort", abort_seen - a0,  32'd1);
    check("t4_rxw",   {16'd0, rx_word}, 32'h00008000);
    check("t4_busy",  {31'd0, busy},    32'd0);
    check("t4_valid", valid_cnt - v0,   32'd0);
    cs_low();
    spi_xfer(16, 16'h5A5A, 1'b0, miso_a);
    cs_high();
    check("t4_next_rxw", {16'd0, rx_word}, 32'h00005A5A);

    // 5: CS release coincides with the 16th rising edge
    v0 = valid_cnt;
    a0 = abort_seen;
    cs_low();
    spi_xfer(16, 16'hC001, 1'b1, miso_a);
    tick(10);
    check("t5_abort", abort_seen - a0,  32'd1);
    check("t5_valid", valid_cnt - v0,   32'd0);
    check("t5_rxw",   {16'd0, rx_word}, 32'h00005A5A);

`ifdef SPI_ABORT_CNT_EN
    // 6: abort counter saturation and reset
    for (int k = 0; k < 260; k++) begin
      cs_low();
      spi_xfer(1, 16'h8000, 1'b0, miso_a);
      cs_high();
    end
    check("t6_sat", {24'd0, abort_cnt}, 32'h000000FF);
    cs_low();
    spi_xfer(3, 16'h0000, 1'b0, miso_a);
    cs_high();
    check("t6_hold", {24'd0, abort_cnt}, 32'h000000FF);
    reset_n = 1'b0;
    tick(2);
    check("t6_rst", {24'd0, abort_cnt}, 32'h00000000);
    reset_n = 1'b1;
    tick(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_spi_word_bridge
`default_nettype wire
